// File: rtl/lsu_bus_master.sv
// lsu_bus_master: turns CPU MEM-stage loads/stores into word-wide handshaked bus transfers,
// using read-modify-write for sub-word stores and extending sub-word load data.
module lsu_bus_master #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_lstype,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_req_ready,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_mem_valid,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            r_state, w_state;
    logic              r_we;
    logic [2:0]        r_lst;
    logic [1:0]        r_off;
    logic [15:0]       r_wd;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_req_ready, w_req_ready;
    logic              r_rsp_valid, w_rsp_valid;
    logic [31:0]       r_rsp_rdata, w_rsp_rdata;
    logic              r_rsp_err, w_rsp_err;
    logic              r_mem_valid, w_mem_valid;
    logic              r_mem_we, w_mem_we;
    logic [31:0]       r_mem_addr, w_mem_addr;
    logic [31:0]       r_mem_wdata, w_mem_wdata;

    logic              w_accept, w_bad, w_wstore;
    logic [15:0]       w_half;
    logic [7:0]        w_byte;
    logic [31:0]       w_load, w_mask, w_rep, w_merge;

    assign w_accept = (r_state == IDLE) && r_req_ready && i_req_valid;
    assign w_bad    = (i_req_lstype == 3'd0 && i_req_addr[1:0] != 2'd0)
                   || ((i_req_lstype == 3'd1 || i_req_lstype == 3'd2) && i_req_addr[0])
                   || (i_req_lstype > 3'd4)
                   || (i_req_we && (i_req_lstype == 3'd2 || i_req_lstype == 3'd4));
    assign w_wstore = i_req_we && (i_req_lstype == 3'd0);

    assign w_half  = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    assign w_byte  = 8'(i_mem_rdata >> {r_off, 3'b000});
    assign w_load  = (r_lst == 3'd1) ? {{16{w_half[15]}}, w_half} :
                     (r_lst == 3'd2) ? {16'd0, w_half} :
                     (r_lst == 3'd3) ? {{24{w_byte[7]}}, w_byte} :
                     (r_lst == 3'd4) ? {24'd0, w_byte} : i_mem_rdata;
    // Store data is replicated across every lane; the mask picks the addressed one.
    assign w_mask  = (r_lst == 3'd1) ? (r_off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF)
                                     : (32'h0000_00FF << {r_off, 3'b000});
    assign w_rep   = (r_lst == 3'd1) ? {2{r_wd}} : {4{r_wd[7:0]}};
    assign w_merge = (i_mem_rdata & ~w_mask) | (w_rep & w_mask);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_lst       <= 3'd0;
            r_off       <= 2'd0;
            r_wd        <= 16'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            r_mem_valid <= w_mem_valid;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            if (w_accept) begin
                r_we  <= i_req_we;
                r_lst <= i_req_lstype;
                r_off <= i_req_addr[1:0];
                r_wd  <= i_req_wdata[15:0];
            end
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = 32'd0;
        w_rsp_err   = 1'b0;
        w_mem_valid = r_mem_valid;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (w_accept) begin
                    w_req_ready = 1'b0;
                    w_cnt       = '0;
                    w_mem_addr  = {i_req_addr[31:2], 2'b00};
                    if (w_bad) begin
                        w_state     = RESP;
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                    end else begin
                        w_state     = w_wstore ? WR : RD;
                        w_mem_valid = 1'b1;
                        w_mem_we    = w_wstore;
                        w_mem_wdata = i_req_wdata;
                    end
                end
            end
            RD, WR: begin
                if (i_mem_ready) begin
                    w_cnt = '0;
                    if (r_state == RD && r_we) begin
                        w_state     = WR;
                        w_mem_we    = 1'b1;
                        w_mem_wdata = w_merge;
                    end else begin
                        w_state     = RESP;
                        w_mem_valid = 1'b0;
                        w_mem_we    = 1'b0;
                        w_rsp_valid = 1'b1;
                        w_rsp_rdata = (r_state == RD) ? w_load : 32'd0;
                    end
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state     = RESP;
                    w_mem_valid = 1'b0;
                    w_mem_we    = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state     = IDLE;
                w_req_ready = 1'b1;
            end
        endcase
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_mem_valid = r_mem_valid;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
endmodule
